// File: rtl/gcd_ctl_pkg.sv
// Shared definitions for the GCD sequencing controller: state encoding and default sizes.
package gcd_ctl_pkg;

  localparam int unsigned GCD_W        = 4;
  localparam int unsigned GCD_MAX_ITER = 15;
  localparam int unsigned GCD_CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_ctl_if.sv
// Requester/consumer handshake bundle for the GCD controller: operand valid/ready and result valid/ready.
interface gcd_ctl_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a_in;
  logic [W-1:0]     b_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic             err;
  logic [CNT_W-1:0] iters;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, result, err, iters
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, result, err, iters
  );
endinterface

// File: rtl/gcd_ctl.sv
// Sequencing controller for the subtractive GCD datapath: operand handshake, zero bypass,
// iteration watchdog and a registered result held until the consumer accepts it.
module gcd_ctl
  import gcd_ctl_pkg::*;
#(
  parameter int unsigned W        = GCD_W,
  parameter int unsigned MAX_ITER = GCD_MAX_ITER,
  parameter int unsigned CNT_W    = GCD_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  gcd_ctl_if.slave     bus,
  output logic         dp_c1,
  output logic         dp_c2,
  output logic         dp_c3,
  input  logic         dp_f,
  input  logic         dp_g,
  input  logic [W-1:0] dp_q
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ITER);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     result_q;
  logic             err_q;
  logic [CNT_W-1:0] iters_q;

  logic             accept;
  logic             zero_op;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             res_ld;
  logic [W-1:0]     res_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] iters_nxt;

  assign accept        = bus.in_valid && (state == IDLE);
  assign zero_op       = (bus.a_in == '0) || (bus.b_in == '0);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.iters     = iters_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dp_c1     = 1'b0;
    dp_c2     = 1'b0;
    dp_c3     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    res_ld    = 1'b0;
    res_nxt   = result_q;
    err_nxt   = 1'b0;
    iters_nxt = count;

    case (state)
      IDLE: begin
        if (accept) begin
          if (zero_op) begin
            // gcd(x,0) = x; the datapath is never loaded
            res_ld    = 1'b1;
            res_nxt   = bus.a_in | bus.b_in;
            iters_nxt = '0;
            state_nxt = DONE;
          end else begin
            dp_c1     = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (dp_g) begin
          res_ld    = 1'b1;
          res_nxt   = dp_q;
          state_nxt = DONE;
        end else if (count == CNT_MAX) begin
          res_ld    = 1'b1;
          res_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (dp_f) begin
          dp_c2   = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          dp_c3   = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // keep the datapath quiet while it is being reset alongside us
    if (rst) begin
      dp_c1 = 1'b0;
      dp_c2 = 1'b0;
      dp_c3 = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      iters_q  <= '0;
    end else begin
      if (cnt_clr) begin
        count <= '0;
      end else if (cnt_inc) begin
        count <= count + CNT_W'(1);
      end
      if (res_ld) begin
        result_q <= res_nxt;
        err_q    <= err_nxt;
        iters_q  <= iters_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gcd_ctl.sv
// Directed bench for gcd_ctl with a behavioural 4-bit subtractive datapath beside it.
module tb_gcd_ctl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcd_ctl_if #(.W(4), .CNT_W(4)) bus ();
  gcd_ctl_if #(.W(4), .CNT_W(4)) bus_t ();

  logic       c1, c2, c3;
  logic       f, g;
  logic [3:0] q, ra, rb;
  logic       t_c1, t_c2, t_c3;
  logic       tie_low = 1'b0;
  logic [3:0] tie_q   = 4'd0;

  gcd_ctl #(.W(4), .MAX_ITER(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dp_c1(c1), .dp_c2(c2), .dp_c3(c3),
    .dp_f(f), .dp_g(g), .dp_q(q)
  );

  // second instance with a short watchdog and status inputs tied low
  gcd_ctl #(.W(4), .MAX_ITER(3), .CNT_W(4)) dut_t (
    .clk(clk), .rst(rst), .bus(bus_t),
    .dp_c1(t_c1), .dp_c2(t_c2), .dp_c3(t_c3),
    .dp_f(tie_low), .dp_g(tie_low), .dp_q(tie_q)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= 4'd0;
      rb <= 4'd0;
    end else if (c1) begin
      ra <= bus.a_in;
      rb <= bus.b_in;
    end else if (c2) begin
      ra <= ra - rb;
    end else if (c3) begin
      rb <= rb - ra;
    end
  end
  assign f = (ra > rb);
  assign g = (ra == rb);
  assign q = g ? ra : 4'd0;

  int n_c1, n_c2, n_c3, n_t2, n_t3, n_multi;
  always @(posedge clk) begin
    if (!rst) begin
      n_c1 <= n_c1 + int'(c1);
      n_c2 <= n_c2 + int'(c2);
      n_c3 <= n_c3 + int'(c3);
      n_t2 <= n_t2 + int'(t_c2);
      n_t3 <= n_t3 + int'(t_c3);
      if (int'(c1) + int'(c2) + int'(c3) > 1) n_multi <= n_multi + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       output int lat, output int d1, output int d2, output int d3);
    int b1, b2, b3;
    b1 = n_c1; b2 = n_c2; b3 = n_c3;
    check("ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.a_in = a; bus.b_in = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a_in = ~a; bus.b_in = ~b;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
    d1 = n_c1 - b1; d2 = n_c2 - b2; d3 = n_c3 - b3;
  endtask

  task automatic release_out;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("idle_after_ack", 32'(bus.in_ready), 32'd1);
    check("ov_low_after_ack", 32'(bus.out_valid), 32'd0);
  endtask

  typedef struct {
    int a, b, res, iters, lat, nc1, nc2, nc3;
  } vec_t;

  vec_t vecs[8] = '{
    '{12,  8,  4,  2,  3, 1,  1,  1},
    '{ 7,  7,  7,  0,  1, 1,  0,  0},
    '{15,  1,  1, 14, 15, 1, 14,  0},
    '{ 0,  9,  9,  0,  0, 0,  0,  0},
    '{ 0,  0,  0,  0,  0, 0,  0,  0},
    '{ 5,  0,  5,  0,  0, 0,  0,  0},
    '{ 3,  9,  3,  2,  3, 1,  0,  2},
    '{ 1, 15,  1, 14, 15, 1,  0, 14}
  };

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int lat, d1, d2, d3, b2, b3;
    bus.in_valid = 1'b0; bus.a_in = 4'd0; bus.b_in = 4'd0; bus.out_ready = 1'b0;
    bus_t.in_valid = 1'b0; bus_t.a_in = 4'd0; bus_t.b_in = 4'd0; bus_t.out_ready = 1'b0;

    rst = 1'b1;
    bus.in_valid = 1'b1; bus.a_in = 4'd3; bus.b_in = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_c1_forced", 32'(c1), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_iters", 32'(bus.iters), 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(4'(vecs[i].a), 4'(vecs[i].b), lat, d1, d2, d3);
      check($sformatf("v%0d_result", i), 32'(bus.result), 32'(vecs[i].res));
      check($sformatf("v%0d_err", i), 32'(bus.err), 32'd0);
      check($sformatf("v%0d_iters", i), 32'(bus.iters), 32'(vecs[i].iters));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_c1_pulses", i), 32'(d1), 32'(vecs[i].nc1));
      check($sformatf("v%0d_c2_pulses", i), 32'(d2), 32'(vecs[i].nc2));
      check($sformatf("v%0d_c3_pulses", i), 32'(d3), 32'(vecs[i].nc3));
      release_out();
    end

    // backpressure: new request presented while result is held
    do_op(4'd6, 4'd4, lat, d1, d2, d3);
    check("bp_first_result", 32'(bus.result), 32'd2);
    d1 = n_c1;
    bus.in_valid = 1'b1; bus.a_in = 4'd9; bus.b_in = 4'd3;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_result_held", 32'(bus.result), 32'd2);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid_high", 32'(bus.out_valid), 32'd1);
    end
    check("bp_no_reload", 32'(n_c1 - d1), 32'd0);
    bus.out_ready = 1'b1;
    check("bp_handshake_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    release_out();

    // reset in the middle of a running operation
    bus.a_in = 4'd13; bus.b_in = 4'd5; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_run_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_c2c3", 32'({c2, c3}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(4'd9, 4'd6, lat, d1, d2, d3);
    check("post_rst_result", 32'(bus.result), 32'd3);
    check("post_rst_iters", 32'(bus.iters), 32'd2);
    check("post_rst_latency", 32'(lat), 32'd3);
    release_out();

    // watchdog abort on the short-timeout instance
    b2 = n_t2; b3 = n_t3;
    bus_t.a_in = 4'd1; bus_t.b_in = 4'd1; bus_t.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_t.in_valid = 1'b0;
    lat = 0;
    while (!bus_t.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("tmo_out_valid", 32'(bus_t.out_valid), 32'd1);
    check("tmo_latency", 32'(lat), 32'd4);
    check("tmo_err", 32'(bus_t.err), 32'd1);
    check("tmo_result", 32'(bus_t.result), 32'd0);
    check("tmo_iters", 32'(bus_t.iters), 32'd3);
    check("tmo_c3_pulses", 32'(n_t3 - b3), 32'd3);
    check("tmo_c2_pulses", 32'(n_t2 - b2), 32'd0);
    bus_t.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_t.out_ready = 1'b0;
    check("tmo_idle_after_ack", 32'(bus_t.in_ready), 32'd1);

    check("ctl_onehot", 32'(n_multi), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
